ram_port_arbiter: RTL and testbench

//  Shares one synchronous 128x8 RAM port between two requesters (ch0, ch1).

---
 rtl/ram_arb_pkg.sv | 17 +
 rtl/rr_arb2.sv | 38 +++
 rtl/ram_port_arbiter.sv | 103 ++++++++++
 tb/tb_ram_port_arbiter.sv | 292 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ram_arb_pkg.sv
// Shared constants and types for the two-channel RAM port arbiter.
// Channel IDs double as the round-robin pointer encoding.
package ram_arb_pkg;

   localparam int AW_DEF   = 7;
   localparam int DW_DEF   = 8;
   localparam int READ_LAT = 3;

   localparam logic CH0 = 1'b0;
   localparam logic CH1 = 1'b1;

   typedef struct packed {
      logic valid;
      logic id;
   } tag_t;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter: combinational grant, registered priority pointer.
// The pointer names the channel that wins the next contested cycle.
module rr_arb2
   import ram_arb_pkg::*;
(
   input  logic       clk,
   input  logic       rst,
   input  logic [1:0] req,
   output logic [1:0] gnt
);

   logic ptr;

   // A lone requester always wins; under contention the pointer decides.
   // Grants are held off while reset is asserted.
   always_comb begin
      gnt = 2'b00;
      if (!rst) begin
         if (req[0] && (!req[1] || ptr == CH0)) begin
            gnt[0] = 1'b1;
         end else if (req[1]) begin
            gnt[1] = 1'b1;
         end
      end
   end

   // After a grant, hand priority to the other channel; hold when idle.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ptr <= CH0;
      end else if (gnt[0]) begin
         ptr <= CH1;
      end else if (gnt[1]) begin
         ptr <= CH0;
      end
   end

endmodule

// File: rtl/ram_port_arbiter.sv
// Shares one synchronous RAM port between two requesters: round-robin accept,
// registered command stage, and a tagged read-return pipeline.
module ram_port_arbiter
   import ram_arb_pkg::*;
#(
   parameter int AW = AW_DEF,
   parameter int DW = DW_DEF
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          req0,
   input  logic          req1,
   input  logic          we0,
   input  logic          we1,
   input  logic [AW-1:0] addr0,
   input  logic [AW-1:0] addr1,
   input  logic [DW-1:0] wdata0,
   input  logic [DW-1:0] wdata1,
   output logic          gnt0,
   output logic          gnt1,
   output logic [DW-1:0] rdata0,
   output logic [DW-1:0] rdata1,
   output logic          rvalid0,
   output logic          rvalid1,
   output logic          mem_en,
   output logic          mem_we,
   output logic [AW-1:0] mem_addr,
   output logic [DW-1:0] mem_wdata,
   input  logic [DW-1:0] mem_rdata
);

   logic [1:0]    gnt;
   logic          any_gnt;
   logic          sel_we;
   logic [AW-1:0] sel_addr;
   logic [DW-1:0] sel_wdata;
   tag_t          tag1;
   tag_t          tag2;

   rr_arb2 u_arb (
      .clk (clk),
      .rst (rst),
      .req ({req1, req0}),
      .gnt (gnt)
   );

   assign gnt0      = gnt[0];
   assign gnt1      = gnt[1];
   assign any_gnt   = |gnt;
   assign sel_we    = gnt[1] ? we1    : we0;
   assign sel_addr  = gnt[1] ? addr1  : addr0;
   assign sel_wdata = gnt[1] ? wdata1 : wdata0;

   // Command stage: the accepted request goes to the RAM next cycle. The
   // address/data fields hold when idle so the port does not toggle needlessly.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         mem_en    <= 1'b0;
         mem_we    <= 1'b0;
         mem_addr  <= '0;
         mem_wdata <= '0;
      end else begin
         mem_en <= any_gnt;
         if (any_gnt) begin
            mem_we    <= sel_we;
            mem_addr  <= sel_addr;
            mem_wdata <= sel_wdata;
         end
      end
   end

   // Tag pipeline: tag1 travels with the command, tag2 lines up with the
   // cycle in which the RAM drives mem_rdata. Writes carry an invalid tag.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         tag1 <= '0;
         tag2 <= '0;
      end else begin
         tag1 <= '{valid: any_gnt & ~sel_we, id: (gnt[1] ? CH1 : CH0)};
         tag2 <= tag1;
      end
   end

   // Response demux: only the addressed channel updates its read data.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rdata0  <= '0;
         rdata1  <= '0;
         rvalid0 <= 1'b0;
         rvalid1 <= 1'b0;
      end else begin
         rvalid0 <= tag2.valid && (tag2.id == CH0);
         rvalid1 <= tag2.valid && (tag2.id == CH1);
         if (tag2.valid && tag2.id == CH0) begin
            rdata0 <= mem_rdata;
         end
         if (tag2.valid && tag2.id == CH1) begin
            rdata1 <= mem_rdata;
         end
      end
   end

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Self-checking bench for ram_port_arbiter: behavioural RAM, reference memory,
// and a timed scoreboard of expected read responses.
module tb_ram_port_arbiter;
   import ram_arb_pkg::*;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       req0 = 1'b0, req1 = 1'b0, we0 = 1'b0, we1 = 1'b0;
   logic [6:0] addr0 = '0, addr1 = '0;
   logic [7:0] wdata0 = '0, wdata1 = '0;
   logic       gnt0, gnt1, rvalid0, rvalid1, mem_en, mem_we;
   logic [7:0] rdata0, rdata1, mem_wdata;
   logic [6:0] mem_addr;
   logic [7:0] mem_rdata = '0;

   typedef struct {
      logic       id;
      logic [7:0] data;
      int         due;
   } exp_t;

   exp_t       sb[$];
   int         tests = 0;
   int         failed = 0;
   int         cyc = 0;
   logic [7:0] ram [128];
   bit [127:0] ram_wr = '0;
   logic [7:0] ref_mem [128];
   bit [127:0] ref_wr = '0;

   always #5 clk = ~clk;

   ram_port_arbiter dut (
      .clk(clk), .rst(rst),
      .req0(req0), .req1(req1), .we0(we0), .we1(we1),
      .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
      .gnt0(gnt0), .gnt1(gnt1),
      .rdata0(rdata0), .rdata1(rdata1), .rvalid0(rvalid0), .rvalid1(rvalid1),
      .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
      .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
   );

   function automatic logic [7:0] preload(input logic [6:0] a);
      return {1'b0, a} ^ 8'hA0;
   endfunction

   // Synchronous RAM with one-cycle read latency, preloaded with a pattern.
   always @(posedge clk) begin
      if (mem_en) begin
         if (mem_we) begin
            ram[mem_addr]    <= mem_wdata;
            ram_wr[mem_addr] <= 1'b1;
         end else begin
            mem_rdata <= ram_wr[mem_addr] ? ram[mem_addr] : preload(mem_addr);
         end
      end
   end

   // One cycle of stimulus; grants feed the scoreboard, responses are popped.
   task automatic tick(input logic r0, input logic w0, input logic [6:0] a0,
                       input logic [7:0] d0, input logic r1, input logic w1,
                       input logic [6:0] a1, input logic [7:0] d1,
                       output logic g0, output logic g1);
      logic e0, e1;
      exp_t e;
      logic [7:0] got;
      req0 = r0; we0 = w0; addr0 = a0; wdata0 = d0;
      req1 = r1; we1 = w1; addr1 = a1; wdata1 = d1;
      #1;
      g0 = gnt0;
      g1 = gnt1;
      tests++;
      if (g0 && g1) begin
         failed++;
         $display("[TB] FAIL dual_grant cyc=%0d: gnt0=%b gnt1=%b, required at most one", cyc, g0, g1);
      end
      if (g0) begin
         if (w0) begin ref_mem[a0] = d0; ref_wr[a0] = 1'b1; end
         else sb.push_back('{id: CH0, data: (ref_wr[a0] ? ref_mem[a0] : preload(a0)), due: cyc + READ_LAT});
      end else if (g1) begin
         if (w1) begin ref_mem[a1] = d1; ref_wr[a1] = 1'b1; end
         else sb.push_back('{id: CH1, data: (ref_wr[a1] ? ref_mem[a1] : preload(a1)), due: cyc + READ_LAT});
      end
      @(negedge clk);
      cyc++;
      req0 = 1'b0;
      req1 = 1'b0;
      e0 = (sb.size() > 0) && (sb[0].due == cyc) && (sb[0].id == CH0);
      e1 = (sb.size() > 0) && (sb[0].due == cyc) && (sb[0].id == CH1);
      tests++;
      if (rvalid0 !== e0) begin
         failed++;
         $display("[TB] FAIL rvalid0 cyc=%0d: got %b, required %b", cyc, rvalid0, e0);
      end
      tests++;
      if (rvalid1 !== e1) begin
         failed++;
         $display("[TB] FAIL rvalid1 cyc=%0d: got %b, required %b", cyc, rvalid1, e1);
      end
      if (sb.size() > 0 && sb[0].due == cyc) begin
         e = sb.pop_front();
         got = e.id ? rdata1 : rdata0;
         tests++;
         if (got !== e.data) begin
            failed++;
            $display("[TB] FAIL rdata%0d cyc=%0d: got %h, required %h", e.id, cyc, got, e.data);
         end
      end
   endtask

   task automatic idle(input int n);
      logic g0, g1;
      for (int i = 0; i < n; i++) tick(0, 0, '0, '0, 0, 0, '0, '0, g0, g1);
   endtask

   task automatic assert_reset();
      rst = 1'b1;
      req0 = 1'b0;
      req1 = 1'b0;
      sb.delete();
      #1;
   endtask

   task automatic release_reset();
      repeat (2) @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic test_reset();
      assert_reset();
      req0 = 1'b1;
      req1 = 1'b1;
      #1;
      tests++;
      if ({gnt0, gnt1} !== 2'b00) begin
         failed++;
         $display("[TB] FAIL reset_gnt: got %b%b, required 00", gnt0, gnt1);
      end
      tests++;
      if ({mem_en, mem_we, mem_addr, mem_wdata} !== '0) begin
         failed++;
         $display("[TB] FAIL reset_cmd: en=%b we=%b addr=%h wdata=%h, required all zero", mem_en, mem_we, mem_addr, mem_wdata);
      end
      tests++;
      if ({rvalid0, rvalid1, rdata0, rdata1} !== '0) begin
         failed++;
         $display("[TB] FAIL reset_resp: rv=%b%b rdata0=%h rdata1=%h, required all zero", rvalid0, rvalid1, rdata0, rdata1);
      end
      req0 = 1'b0;
      req1 = 1'b0;
      release_reset();
   endtask

   task automatic test_single_read();
      logic g0, g1;
      tick(1, 0, 7'h05, '0, 0, 0, '0, '0, g0, g1);
      tests++;
      if ({g0, g1} !== 2'b10) begin
         failed++;
         $display("[TB] FAIL single_gnt: got gnt0=%b gnt1=%b, required 1 0", g0, g1);
      end
      tests++;
      if ({mem_en, mem_we, mem_addr} !== {1'b1, 1'b0, 7'h05}) begin
         failed++;
         $display("[TB] FAIL single_cmd: en=%b we=%b addr=%h, required 1 0 05", mem_en, mem_we, mem_addr);
      end
      idle(3);
      tests++;
      if (rdata0 !== 8'hA5) begin
         failed++;
         $display("[TB] FAIL single_rdata: got %h, required a5", rdata0);
      end
   endtask

   task automatic test_contention();
      logic g0, g1;
      logic [6:0] want;
      assert_reset();
      release_reset();
      for (int i = 0; i < 4; i++) begin
         tick(1, 0, 7'(16 + i), '0, 1, 0, 7'(32 + i), '0, g0, g1);
         tests++;
         if (g0 !== (i % 2 == 0) || g1 !== (i % 2 == 1)) begin
            failed++;
            $display("[TB] FAIL rr_gnt step %0d: got gnt0=%b gnt1=%b, required %0d %0d", i, g0, g1, (i % 2 == 0), (i % 2 == 1));
         end
         want = (i % 2 == 0) ? 7'(16 + i) : 7'(32 + i);
         tests++;
         if (mem_en !== 1'b1 || mem_addr !== want) begin
            failed++;
            $display("[TB] FAIL rr_addr step %0d: en=%b addr=%h, required 1 %h", i, mem_en, mem_addr, want);
         end
      end
      idle(4);
      tests++;
      if (sb.size() != 0) begin
         failed++;
         $display("[TB] FAIL rr_drain: %0d responses missing, required 0", sb.size());
      end
   endtask

   task automatic test_write_then_read();
      logic g0, g1;
      tick(0, 0, '0, '0, 1, 1, 7'h7F, 8'h3C, g0, g1);
      tests++;
      if (g1 !== 1'b1 || mem_we !== 1'b1 || mem_addr !== 7'h7F || mem_wdata !== 8'h3C) begin
         failed++;
         $display("[TB] FAIL wr_cmd: gnt1=%b we=%b addr=%h wdata=%h, required 1 1 7f 3c", g1, mem_we, mem_addr, mem_wdata);
      end
      tick(1, 0, 7'h7F, '0, 0, 0, '0, '0, g0, g1);
      tests++;
      if (g0 !== 1'b1) begin
         failed++;
         $display("[TB] FAIL raw_gnt: got gnt0=%b, required 1", g0);
      end
      idle(4);
      tests++;
      if (rdata0 !== 8'h3C || sb.size() != 0) begin
         failed++;
         $display("[TB] FAIL raw_rdata: got %h pending=%0d, required 3c pending=0", rdata0, sb.size());
      end
   endtask

   task automatic test_back_to_back();
      logic g0, g1;
      for (int i = 0; i < 4; i++) begin
         tick(1, 0, 7'(i), '0, 0, 0, '0, '0, g0, g1);
         tests++;
         if (g0 !== 1'b1) begin
            failed++;
            $display("[TB] FAIL b2b_gnt %0d: got %b, required 1", i, g0);
         end
      end
      idle(4);
      tests++;
      if (rdata0 !== 8'hA3 || sb.size() != 0) begin
         failed++;
         $display("[TB] FAIL b2b_last: rdata0=%h pending=%0d, required a3 pending=0", rdata0, sb.size());
      end
   endtask

   task automatic test_reset_midflight();
      logic g0, g1;
      tick(1, 0, 7'h11, '0, 0, 0, '0, '0, g0, g1);
      tick(0, 0, '0, '0, 1, 0, 7'h22, '0, g0, g1);
      tests++;
      if (g1 !== 1'b1) begin
         failed++;
         $display("[TB] FAIL mid_gnt1: got %b, required 1", g1);
      end
      assert_reset();
      tests++;
      if ({mem_en, mem_we, mem_addr, mem_wdata, rvalid0, rvalid1, rdata0, rdata1} !== '0) begin
         failed++;
         $display("[TB] FAIL mid_reset_outputs: en=%b we=%b addr=%h rv=%b%b rdata0=%h rdata1=%h, required all zero",
                  mem_en, mem_we, mem_addr, rvalid0, rvalid1, rdata0, rdata1);
      end
      release_reset();
      idle(5);
      tick(1, 0, 7'h30, '0, 1, 0, 7'h31, '0, g0, g1);
      tests++;
      if ({g0, g1} !== 2'b10) begin
         failed++;
         $display("[TB] FAIL post_reset_gnt: got gnt0=%b gnt1=%b, required 1 0", g0, g1);
      end
      idle(4);
      tests++;
      if (sb.size() != 0) begin
         failed++;
         $display("[TB] FAIL post_reset_drain: %0d responses missing, required 0", sb.size());
      end
   endtask

   initial begin
      @(negedge clk);
      test_reset();
      test_single_read();
      test_contention();
      test_write_then_read();
      test_back_to_back();
      test_reset_midflight();
      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation did not finish, required completion");
      $fatal(1, "[TB] timeout");
   end

endmodule
